// File: rtl/carry_gen.sv
// carry_gen: registered carry-in decode for the 128-bit ALU adder LSB
module carry_gen (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Opsel,
  input  logic       Mode,
  output logic       Carry
);
  logic w_carry;
  logic r_carry;
  always_comb begin
    w_carry = 1'b0;
    case ({Mode, Opsel})
      4'b0000: w_carry = 1'b0;
      4'b0001: w_carry = 1'b1;
      4'b0010: w_carry = 1'b1;
      4'b0011: w_carry = 1'b0;
      4'b0100: w_carry = 1'b0;
      4'b0101: w_carry = 1'b1;
      4'b0110: w_carry = 1'b1;
      4'b0111: w_carry = 1'b1;
      4'b1000: w_carry = 1'b0;
      4'b1001: w_carry = 1'b0;
      4'b1010: w_carry = 1'b0;
      4'b1011: w_carry = 1'b0;
      4'b1100: w_carry = 1'b0;
      4'b1101: w_carry = 1'b0;
      4'b1110: w_carry = 1'b0;
      4'b1111: w_carry = 1'b0;
      default: w_carry = 1'b0;
    endcase
  end
  always_ff @(posedge Clk)
    r_carry <= Reset ? 1'b0 : w_carry;
  assign Carry = r_carry;
endmodule

// File: tb/tb_carry_gen.sv
// tb_carry_gen: model-checked directed test of the carry-in generator
module tb_carry_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opsel = 3'd1;
  logic       mode = 1'b0;
  logic       carry;
  int         total = 0;
  int         bad = 0;
  logic       started = 1'b0;
  logic       exp_m = 1'b0;
  logic       lit_on = 1'b0;
  logic       lit_exp = 1'b0;
  string      lit_name = "";
  logic [7:0]  arith_lit = 8'b1110_0110;
  logic [15:0] exh_lit = 16'h00E6;

  carry_gen dut (
    .Clk(clk),
    .Reset(reset),
    .Opsel(opsel),
    .Mode(mode),
    .Carry(carry)
  );

  always #5 clk = ~clk;

  // Carry-in is 1 exactly for arithmetic ops whose formula adds a trailing +1
  function automatic logic decode(input logic m, input logic [2:0] o);
    return !m && (o inside {3'd1, 3'd2, 3'd5, 3'd6, 3'd7});
  endfunction

  always @(posedge clk) begin
    exp_m   <= reset ? 1'b0 : decode(mode, opsel);
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      total++;
      if (carry !== exp_m) begin
        bad++;
        $display("FAIL model t=%0t carry=%b want=%b", $time, carry, exp_m);
      end
      if (lit_on) begin
        total++;
        if (carry !== lit_exp) begin
          bad++;
          $display("FAIL %s carry=%b want=%b", lit_name, carry, lit_exp);
        end
      end
    end
  end

  task automatic step(input logic r, input logic m, input logic [2:0] o,
                      input logic e, input string nm);
    reset = r; mode = m; opsel = o;
    lit_on = 1'b1; lit_exp = e; lit_name = nm;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    step(1'b1, 1'b0, 3'd1, 1'b0, "rst_hold0");
    step(1'b1, 1'b0, 3'd1, 1'b0, "rst_hold1");
    step(1'b0, 1'b0, 3'd1, 1'b1, "rst_release");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'(i), arith_lit[i], $sformatf("arith%0d", i));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 1'b0, $sformatf("logic%0d", i));
    step(1'b0, 1'b0, 3'd2, 1'b1, "toggle_m0");
    step(1'b0, 1'b1, 3'd2, 1'b0, "toggle_m1");
    step(1'b0, 1'b0, 3'd2, 1'b1, "toggle_m0b");
    step(1'b0, 1'b0, 3'd7, 1'b1, "mid_pre");
    step(1'b1, 1'b0, 3'd7, 1'b0, "mid_rst");
    step(1'b0, 1'b0, 3'd7, 1'b1, "mid_post");
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      step(1'b0, kk[3], kk[2:0], exh_lit[k], $sformatf("exh%0d", k));
    end
    for (int k = 15; k >= 0; k--) begin
      logic [3:0] kk;
      kk = 4'(k);
      step(1'b0, kk[3], kk[2:0], exh_lit[k], $sformatf("exh_rev%0d", k));
    end
    lit_on = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
